// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the WISC pipeline sequencing controller.
//   state_e    : controller state (RUN, DSTALL, HALTED)
//   REG_ADDR_W : width of a register-file address
//   rule_e     : priority-ordered sequencing rules; a lower value wins
//   pick_rule  : selects the highest-priority active rule for a cycle
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RULE_DMEM_STALL = 3'd1,
        RULE_HALT       = 3'd2,
        RULE_REDIRECT   = 3'd3,
        RULE_LOAD_USE   = 3'd4,
        RULE_IMEM_STALL = 3'd5,
        RULE_ADVANCE    = 3'd6
    } rule_e;

    // First match wins; the order of the tests is the priority order.
    function automatic rule_e pick_rule(
        input logic dmem_busy,
        input logic memwb_halt,
        input logic redirect,
        input logic load_use,
        input logic imem_busy
    );
        if (dmem_busy)       return RULE_DMEM_STALL;
        else if (memwb_halt) return RULE_HALT;
        else if (redirect)   return RULE_REDIRECT;
        else if (load_use)   return RULE_LOAD_USE;
        else if (imem_busy)  return RULE_IMEM_STALL;
        else                 return RULE_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Hazard inputs from the datapath and enable/flush outputs to the pipeline
// registers, bundled for the sequencing controller.
//   master : the controller (reads hazard info, drives enables/flushes)
//   slave  : the datapath side (drives hazard info, reads enables/flushes)
// Hazard info : ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt, idex_rd,
//               idex_load, exmem_redirect, memwb_halt, imem_busy, dmem_busy
// Controls    : pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
//               idex_flush, exmem_flush, pc_sel_redirect, halted
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;

    logic [pipe_ctrl_pkg::REG_ADDR_W-1:0] ifid_rs;
    logic [pipe_ctrl_pkg::REG_ADDR_W-1:0] ifid_rt;
    logic                                 ifid_uses_rs;
    logic                                 ifid_uses_rt;
    logic [pipe_ctrl_pkg::REG_ADDR_W-1:0] idex_rd;
    logic                                 idex_load;
    logic                                 exmem_redirect;
    logic                                 memwb_halt;
    logic                                 imem_busy;
    logic                                 dmem_busy;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel_redirect;
    logic halted;

    modport master (
        input  ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt, idex_rd,
               idex_load, exmem_redirect, memwb_halt, imem_busy, dmem_busy,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, pc_sel_redirect, halted
    );

    modport slave (
        output ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt, idex_rd,
               idex_load, exmem_redirect, memwb_halt, imem_busy, dmem_busy,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, pc_sel_redirect, halted
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset, clears count
//   inc   : count this cycle
//   count : current value (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the five-stage WISC core. Each cycle it
// drives the PC / IF-ID / ID-EX / EX-MEM / MEM-WB enables and bubble flushes,
// resolving data-memory stalls, halt retirement, MEM-stage redirects,
// load-use hazards and instruction-memory stalls (in that priority).
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   bus          : pipe_ctrl_if.master (hazard inputs, enable/flush outputs)
//   stall_cycles : cycles with the PC frozen (saturating)
//   flush_events : redirect flushes (saturating)
// Optional feature macro: PIPE_CTRL_PERF_EN. When undefined the two counter
// outputs are tied to zero and no counter flops are built.
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.master      bus,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    state_e state;
    state_e state_nxt;
    rule_e  rule;
    logic   load_use;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush;
    logic pc_sel_redirect, halted;

    // Register 0 is deliberately not excluded: a match on r0 still stalls.
    assign load_use = bus.idex_load &
                      ((bus.ifid_uses_rs & (bus.ifid_rs == bus.idex_rd)) |
                       (bus.ifid_uses_rt & (bus.ifid_rt == bus.idex_rd)));

    assign rule = pick_rule(bus.dmem_busy, bus.memwb_halt, bus.exmem_redirect,
                            load_use, bus.imem_busy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN and DSTALL share the same rules, which makes leaving DSTALL free:
    // the release cycle already advances the pipe. A flushed register always
    // has its enable set so the bubble is actually captured.
    always_comb begin
        pc_en           = 1'b0;
        ifid_en         = 1'b0;
        idex_en         = 1'b0;
        exmem_en        = 1'b0;
        memwb_en        = 1'b0;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        exmem_flush     = 1'b0;
        pc_sel_redirect = 1'b0;
        halted          = 1'b0;
        state_nxt       = state;

        if (!rst) begin
            state_nxt = RUN;
        end else if (state == HALTED) begin
            halted = 1'b1;
        end else begin
            state_nxt = RUN;
            unique case (rule)
                RULE_DMEM_STALL: begin
                    state_nxt = DSTALL;
                end
                RULE_HALT: begin
                    memwb_en  = 1'b1;
                    state_nxt = HALTED;
                end
                RULE_REDIRECT: begin
                    pc_en           = 1'b1;
                    ifid_en         = 1'b1;
                    idex_en         = 1'b1;
                    exmem_en        = 1'b1;
                    memwb_en        = 1'b1;
                    ifid_flush      = 1'b1;
                    idex_flush      = 1'b1;
                    exmem_flush     = 1'b1;
                    pc_sel_redirect = 1'b1;
                end
                RULE_LOAD_USE: begin
                    // Hold the consumer in IF/ID for one cycle while the load
                    // moves on to EX/MEM; ID/EX receives a bubble.
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                end
                RULE_IMEM_STALL: begin
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            endcase
        end
    end

    assign bus.pc_en           = pc_en;
    assign bus.ifid_en         = ifid_en;
    assign bus.idex_en         = idex_en;
    assign bus.exmem_en        = exmem_en;
    assign bus.memwb_en        = memwb_en;
    assign bus.ifid_flush      = ifid_flush;
    assign bus.idex_flush      = idex_flush;
    assign bus.exmem_flush     = exmem_flush;
    assign bus.pc_sel_redirect = pc_sel_redirect;
    assign bus.halted          = halted;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = rst & (state != HALTED) & ~pc_en;
    assign flush_inc = rst & (state != HALTED) & (rule == RULE_REDIRECT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: vector table, hand-written multi-cycle
// sequences, and randomized traffic against a reference model. A second
// instance with CNT_W=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int CNT_W = 16;

    // Output vector bit order:
    // [9]pc_en [8]ifid_en [7]idex_en [6]exmem_en [5]memwb_en
    // [4]ifid_flush [3]idex_flush [2]exmem_flush [1]pc_sel_redirect [0]halted
    localparam logic [9:0] O_ZERO  = 10'b00000_000_00;
    localparam logic [9:0] O_ALL   = 10'b11111_000_00;
    localparam logic [9:0] O_LU    = 10'b00111_010_00;
    localparam logic [9:0] O_IMEM  = 10'b01111_100_00;
    localparam logic [9:0] O_REDIR = 10'b11111_111_10;
    localparam logic [9:0] O_HALT  = 10'b00001_000_00;
    localparam logic [9:0] O_PARK  = 10'b00000_000_01;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [2:0] rd;
        logic       load;
        logic       redirect;
        logic       halt;
        logic       imem;
        logic       dmem;
    } vec_in_t;

    typedef struct packed {
        vec_in_t    in;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl_if bus2 ();
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic [1:0]       sc2, fe2;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    pipe_ctrl #(.CNT_W(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus2),
        .stall_cycles (sc2),
        .flush_events (fe2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_in_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                   input int rd, input bit ld, input bit redir,
                                   input bit halt, input bit imem, input bit dmem);
        vec_in_t v;
        v.rs = 3'(rs); v.rt = 3'(rt); v.uses_rs = urs; v.uses_rt = urt;
        v.rd = 3'(rd); v.load = ld; v.redirect = redir; v.halt = halt;
        v.imem = imem; v.dmem = dmem;
        return v;
    endfunction

    task automatic drive(input vec_in_t v);
        bus.ifid_rs        = v.rs;
        bus.ifid_rt        = v.rt;
        bus.ifid_uses_rs   = v.uses_rs;
        bus.ifid_uses_rt   = v.uses_rt;
        bus.idex_rd        = v.rd;
        bus.idex_load      = v.load;
        bus.exmem_redirect = v.redirect;
        bus.memwb_halt     = v.halt;
        bus.imem_busy      = v.imem;
        bus.dmem_busy      = v.dmem;
    endtask

    task automatic drive2(input vec_in_t v);
        bus2.ifid_rs        = v.rs;
        bus2.ifid_rt        = v.rt;
        bus2.ifid_uses_rs   = v.uses_rs;
        bus2.ifid_uses_rt   = v.uses_rt;
        bus2.idex_rd        = v.rd;
        bus2.idex_load      = v.load;
        bus2.exmem_redirect = v.redirect;
        bus2.memwb_halt     = v.halt;
        bus2.imem_busy      = v.imem;
        bus2.dmem_busy      = v.dmem;
    endtask

    function automatic logic [9:0] outs();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
                bus.pc_sel_redirect, bus.halted};
    endfunction

    function automatic logic [9:0] outs2();
        return {bus2.pc_en, bus2.ifid_en, bus2.idex_en, bus2.exmem_en, bus2.memwb_en,
                bus2.ifid_flush, bus2.idex_flush, bus2.exmem_flush,
                bus2.pc_sel_redirect, bus2.halted};
    endfunction

    // Reference: what the pipe should do this cycle, straight from the rule list.
    function automatic logic [9:0] ref_outs(input vec_in_t v, input bit parked);
        bit hazard;
        hazard = v.load && ((v.uses_rs && v.rs == v.rd) || (v.uses_rt && v.rt == v.rd));
        if (parked)     return O_PARK;
        if (v.dmem)     return O_ZERO;
        if (v.halt)     return O_HALT;
        if (v.redirect) return O_REDIR;
        if (hazard)     return O_LU;
        if (v.imem)     return O_IMEM;
        return O_ALL;
    endfunction

    // One cycle boundary: called just after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Brief asynchronous reset between clock edges.
    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl [12];
        vec_in_t idle;
        vec_in_t v;
        logic [9:0] e;
        bit      parked;
        int      park_len;
        longint  m_stall, m_flush;
        longint  cmax;

        idle = '0;
        cmax = (64'd1 << CNT_W) - 1;
        drive(idle);
        drive2(idle);

        // ---------------- reset state ----------------
        rst = 1'b0;
        #12;
        check("reset_outs", 32'(outs()), 32'(O_ZERO));
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_flush", 32'(flush_events), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // ---------------- vector table ----------------
        tbl[0].in  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tbl[0].exp  = O_ALL;
        tbl[1].in  = mk(3, 1, 1, 0, 3, 1, 0, 0, 0, 0); tbl[1].exp  = O_LU;
        tbl[2].in  = mk(2, 5, 0, 1, 5, 1, 0, 0, 0, 0); tbl[2].exp  = O_LU;
        tbl[3].in  = mk(3, 1, 0, 1, 3, 1, 0, 0, 0, 0); tbl[3].exp  = O_ALL;
        tbl[4].in  = mk(3, 3, 1, 1, 3, 0, 0, 0, 0, 0); tbl[4].exp  = O_ALL;
        tbl[5].in  = mk(0, 6, 1, 0, 0, 1, 0, 0, 0, 0); tbl[5].exp  = O_LU;
        tbl[6].in  = mk(1, 2, 1, 1, 4, 1, 0, 0, 1, 0); tbl[6].exp  = O_IMEM;
        tbl[7].in  = mk(3, 1, 1, 0, 3, 1, 1, 0, 1, 0); tbl[7].exp  = O_REDIR;
        tbl[8].in  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1); tbl[8].exp  = O_ZERO;
        tbl[9].in  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); tbl[9].exp  = O_HALT;
        tbl[10].in = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); tbl[10].exp = O_ZERO;
        tbl[11].in = mk(7, 7, 1, 1, 7, 1, 0, 0, 1, 0); tbl[11].exp = O_LU;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].in);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            next_cycle();
            drive(idle);
            pulse_reset();
        end

        // ---------------- load-use then release ----------------
        drive(mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0));
        @(negedge clk);
        check("lu_stall", 32'(outs()), 32'(O_LU));
        next_cycle();
        drive(mk(3, 0, 1, 0, 3, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("lu_release", 32'(outs()), 32'(O_ALL));
        next_cycle();
        drive(idle);
        pulse_reset();

        // ---------------- redirect over load-use and imem ----------------
        drive(mk(3, 3, 1, 1, 3, 1, 1, 0, 1, 0));
        @(negedge clk);
        check("redir_outs", 32'(outs()), 32'(O_REDIR));
        check("redir_flush_before", 32'(flush_events), 32'd0);
        next_cycle();
        drive(idle);
        @(negedge clk);
        check("redir_flush_after", 32'(flush_events), PERF ? 32'd1 : 32'd0);
        next_cycle();
        pulse_reset();

        // ---------------- dmem stall for 4 cycles ----------------
        for (int i = 0; i < 4; i++) begin
            drive(mk(3, 3, 1, 1, 3, 1, 1, 1, 1, 1));
            @(negedge clk);
            check($sformatf("dstall_outs%0d", i), 32'(outs()), 32'(O_ZERO));
            if (i > 0) check($sformatf("dstall_state%0d", i), 32'(dut.state), 32'(DSTALL));
            next_cycle();
        end
        drive(idle);
        @(negedge clk);
        check("dstall_release", 32'(outs()), 32'(O_ALL));
        check("dstall_state_last", 32'(dut.state), 32'(DSTALL));
        check("dstall_count", 32'(stall_cycles), PERF ? 32'd4 : 32'd0);
        next_cycle();
        @(negedge clk);
        check("dstall_back_run", 32'(dut.state), 32'(RUN));
        check("dstall_count_hold", 32'(stall_cycles), PERF ? 32'd4 : 32'd0);
        next_cycle();

        // ---------------- reset mid-DSTALL ----------------
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        next_cycle();
        drive(idle);
        rst = 1'b0;
        #1;
        check("rst_dstall_outs", 32'(outs()), 32'(O_ZERO));
        check("rst_dstall_cnt", 32'(stall_cycles), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_dstall_run", 32'(outs()), 32'(O_ALL));
        check("rst_dstall_state", 32'(dut.state), 32'(RUN));
        next_cycle();

        // ---------------- halt retirement ----------------
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        @(negedge clk);
        check("halt_entry", 32'(outs()), 32'(O_HALT));
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(mk(3, 3, 1, 1, 3, 1, i[0], 0, 1, i[1]));
            @(negedge clk);
            check($sformatf("halt_park%0d", i), 32'(outs()), 32'(O_PARK));
            next_cycle();
        end
        drive(idle);
        rst = 1'b0;
        #1;
        check("rst_halt_outs", 32'(outs()), 32'(O_ZERO));
        check("rst_halt_stall", 32'(stall_cycles), 32'd0);
        check("rst_halt_flush", 32'(flush_events), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_halt_run", 32'(outs()), 32'(O_ALL));
        check("rst_halt_state", 32'(dut.state), 32'(RUN));
        next_cycle();

        // ---------------- saturation on the narrow instance ----------------
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive2(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            next_cycle();
        end
        drive2(idle);
        @(negedge clk);
        check("sat_stall", 32'(sc2), PERF ? 32'd3 : 32'd0);
        check("sat_flush", 32'(fe2), 32'd0);
        check("sat_outs", 32'(outs2()), 32'(O_ALL));
        next_cycle();

        // ---------------- randomized traffic vs reference ----------------
        pulse_reset();
        parked   = 1'b0;
        park_len = 0;
        m_stall  = 0;
        m_flush  = 0;
        for (int n = 0; n < 600; n++) begin
            if (($urandom_range(0, 99) == 0) || park_len > 3) begin
                pulse_reset();
                parked   = 1'b0;
                park_len = 0;
                m_stall  = 0;
                m_flush  = 0;
            end
            v.rs       = 3'($urandom_range(0, 3));
            v.rt       = 3'($urandom_range(0, 3));
            v.rd       = 3'($urandom_range(0, 3));
            v.uses_rs  = 1'($urandom_range(0, 1));
            v.uses_rt  = 1'($urandom_range(0, 1));
            v.load     = 1'($urandom_range(0, 1));
            v.redirect = ($urandom_range(0, 5) == 0);
            v.halt     = ($urandom_range(0, 29) == 0);
            v.imem     = ($urandom_range(0, 4) == 0);
            v.dmem     = ($urandom_range(0, 4) == 0);
            drive(v);
            @(negedge clk);
            e = ref_outs(v, parked);
            check("rnd_outs", 32'(outs()), 32'(e));
            check("rnd_stall", 32'(stall_cycles), PERF ? 32'(m_stall) : 32'd0);
            check("rnd_flush", 32'(flush_events), PERF ? 32'(m_flush) : 32'd0);
            @(posedge clk);
            if (!parked) begin
                if (!e[9] && m_stall < cmax) m_stall++;
                if (e[1] && m_flush < cmax)  m_flush++;
                if (!v.dmem && v.halt) parked = 1'b1;
            end else begin
                park_len++;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage WISC core. Every cycle it drives the enables and flushes of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions:
- load-use hazards;
- taken-branch/jump redirects resolved in MEM;
- instruction- and data-memory stalls;
- halt retirement.

It holds a small state machine that freezes the pipe on data-memory stalls and parks it after a halt.

## Interface
- CNT_W, 16, width of the optional performance counters
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ifid_rs  in  3  source register A of the instruction in IF/ID
- ifid_rt  in  3  source register B of the instruction in IF/ID
- ifid_uses_rs  in  1  IF/ID instruction reads rs
- ifid_uses_rt  in  1  IF/ID instruction reads rt
- idex_rd  in  3  destination register of the instruction in ID/EX
- idex_load  in  1  ID/EX instruction is a load (mem_to_reg and regWrite)
- exmem_redirect  in  1  EX/MEM holds a taken branch or jump (PC must load newPC)
- memwb_halt  in  1  halt instruction is in MEM/WB
- imem_busy  in  1  instruction memory has not returned a valid word this cycle
- dmem_busy  in  1  data memory access in MEM not complete this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a NOP/bubble (all control bits 0) instead of the input
- pc_sel_redirect  out  1  PC loads the redirect target instead of PC+2
- halted  out  1  pipeline parked after a halt retired
- stall_cycles  out  CNT_W  stall cycle count (see Configuration)
- flush_events  out  CNT_W  redirect flush count (see Configuration)

## Operation
- States: RUN, DSTALL, HALTED. Reset state is RUN.
- Outputs in RUN and DSTALL are evaluated by priority, first match wins:
  1. dmem_busy=1: all *_en=0, all flushes=0. Next state DSTALL.
  2. memwb_halt=1: memwb_en=1, all other *_en=0. Next state HALTED.
  3. exmem_redirect=1: all *_en=1, pc_sel_redirect=1, ifid_flush=idex_flush=exmem_flush=1. flush_events increments.
  4. Load-use: idex_load & ((ifid_uses_rs & rs==idex_rd) | (ifid_uses_rt & rt==idex_rd)). Then pc_en=ifid_en=0, idex_flush=1; idex_en, exmem_en, memwb_en=1.
  5. imem_busy=1: pc_en=0, ifid_flush=1; other *_en=1.
  6. Otherwise all *_en=1 and no flushes.
- DSTALL: the same priority rules apply, so release is zero-penalty. When dmem_busy=0, the cycle behaves as RUN and the next state is RUN.
- HALTED: all *_en=0, flushes=0, halted=1. Exited only by reset. All other inputs are ignored.
- A flush takes priority over an enable for the same register: a flushed register is loaded with a bubble and its enable is 1.
- A register-0 match counts as a hazard. No special zero-register rule applies.

## Timing
- Purely combinational from inputs and state to enables/flushes. The state register and counters update on the clk rising edge.
- While rst=0: all *_en=0, flushes=0, pc_sel_redirect=0, halted=0, counters=0, state=RUN.
- rst deassertion takes effect asynchronously. The first clk edge after release runs RUN rules.
- A load-use hazard stalls exactly one cycle, because the load advances to EX/MEM.
- A redirect costs three squashed slots.
- A halt is retired with memwb_en=1 on the cycle of entry. halted=1 from the next cycle.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments on every cycle with pc_en=0 while not HALTED and rst=1.
  - flush_events increments on every rule-3 cycle.
  - Both saturate at all-ones.
- PIPE_CTRL_PERF_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum (RUN=2'd0, DSTALL=2'd1, HALTED=2'd2);
  - REG_ADDR_W=3;
  - the rule-priority constants.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice under PIPE_CTRL_PERF_EN.

## Test plan
- Load-use: idex_load=1, idex_rd=3, ifid_rs=3, ifid_uses_rs=1 for one cycle → pc_en=ifid_en=0, idex_flush=1, exmem_en=1. The next cycle with idex_load=0 → all *_en=1.
- Redirect with a simultaneous load-use and imem_busy → pc_sel_redirect=1, three flushes=1, pc_en=1. With PERF_EN, flush_events goes 0→1.
- dmem_busy held for 4 cycles → all *_en=0 for 4 cycles, state DSTALL. Cycle 5 with dmem_busy=0 → all *_en=1, state RUN. With PERF_EN, stall_cycles=4.
- memwb_halt=1 → memwb_en=1, others 0. halted=1 on the following cycles, regardless of exmem_redirect/dmem_busy toggling.
- rst pulled low mid-DSTALL and mid-HALTED → outputs go to reset values immediately. After release: RUN, counters=0.
- PERF_EN with CNT_W=2: force 5 stall cycles → stall_cycles sticks at 3.
